// File: rtl/ft232h_pkg.sv
// Shared types and constants for the FT232H transmit packetizer.
package ft232h_pkg;

    typedef enum logic [2:0] {
        StFill,
        StSync,
        StSeq,
        StLen,
        StPayload,
        StCsum
    } pkt_state_t;

    localparam logic [7:0]  SYNC_BYTE_DFLT = 8'hA5;
    localparam int unsigned HDR_LEN        = 3;

    typedef struct packed {
        logic [1:0]  channel;
        logic [15:0] data;
    } sample_t;

endpackage

// File: rtl/ft232h_sample_buffer.sv
// One-packet sample store: synchronous write, combinational read, storage not reset.
module ft232h_sample_buffer
    import ft232h_pkg::*;
#(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  sample_t           i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output sample_t           o_rdata
);

    sample_t mem_q [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/ft232h_tx_packetizer.sv
// Buffers up to one packet of tagged samples and emits SYNC/SEQ/LEN/payload/CSUM bytes
// over a valid/ready byte port feeding the FT232H FIFO controller.
module ft232h_tx_packetizer
    import ft232h_pkg::*;
#(
    parameter int unsigned SAMPLES_PER_PKT = 8,
    parameter logic [7:0]  SYNC_BYTE       = SYNC_BYTE_DFLT
) (
    input  logic        i_clk,
    input  logic        i_ft232h_reset_n,
    input  logic [15:0] i_sample_data,
    input  logic [1:0]  i_sample_channel,
    input  logic        i_sample_valid,
    output logic        o_sample_ready,
    input  logic        i_flush,
    output logic [7:0]  o_byte_data,
    output logic        o_byte_valid,
    input  logic        i_byte_ready,
    output logic        o_busy,
    output logic        o_pkt_done
);

    localparam int unsigned AddrW = (SAMPLES_PER_PKT > 1) ? $clog2(SAMPLES_PER_PKT) : 1;

    pkt_state_t state_q, state_d;
    logic [7:0] count_q, count_d;
    logic [7:0] seq_q, seq_d;
    logic [7:0] len_q, len_d;
    logic [7:0] csum_q, csum_d;
    logic [7:0] idx_q, idx_d;
    logic [1:0] bidx_q, bidx_d;
    logic [7:0] byte_data_q, byte_data_d;
    logic       byte_valid_q, byte_valid_d;
    logic       pkt_done_q, pkt_done_d;

    logic             accept;
    logic             hs;
    logic [8:0]       count_inc;
    logic [7:0]       csum_add;
    logic [AddrW-1:0] raddr;
    sample_t          wr_sample;
    sample_t          rd_sample;

    assign accept    = i_sample_valid && (state_q == StFill);
    assign hs        = byte_valid_q && i_byte_ready;
    assign count_inc = {1'b0, count_q} + {8'd0, accept};
    assign csum_add  = csum_q + byte_data_q;
    assign wr_sample = '{channel: i_sample_channel, data: i_sample_data};
    // Look ahead to the sample whose first byte is loaded on the next handshake.
    assign raddr     = (bidx_q == 2'd2) ? AddrW'(idx_q + 8'd1) : AddrW'(idx_q);

    ft232h_sample_buffer #(
        .DEPTH  (SAMPLES_PER_PKT),
        .ADDR_W (AddrW)
    ) u_buffer (
        .i_clk   (i_clk),
        .i_we    (accept),
        .i_waddr (AddrW'(count_q)),
        .i_wdata (wr_sample),
        .i_raddr (raddr),
        .o_rdata (rd_sample)
    );

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        seq_d        = seq_q;
        len_d        = len_q;
        csum_d       = csum_q;
        idx_d        = idx_q;
        bidx_d       = bidx_q;
        byte_data_d  = byte_data_q;
        byte_valid_d = byte_valid_q;
        pkt_done_d   = 1'b0;

        unique case (state_q)
            StFill: begin
                count_d = count_inc[7:0];
                // A sample arriving with flush is counted before the packet closes.
                if ((count_inc == 9'(SAMPLES_PER_PKT)) || (i_flush && (count_inc != 9'd0))) begin
                    state_d      = StSync;
                    len_d        = count_inc[7:0];
                    byte_data_d  = SYNC_BYTE;
                    byte_valid_d = 1'b1;
                    csum_d       = 8'd0;
                    idx_d        = 8'd0;
                    bidx_d       = 2'd0;
                end
            end
            StSync: begin
                if (hs) begin
                    state_d     = StSeq;
                    byte_data_d = seq_q;
                end
            end
            StSeq: begin
                if (hs) begin
                    state_d     = StLen;
                    csum_d      = csum_add;
                    byte_data_d = len_q;
                end
            end
            StLen: begin
                if (hs) begin
                    state_d     = StPayload;
                    csum_d      = csum_add;
                    byte_data_d = {6'd0, rd_sample.channel};
                end
            end
            StPayload: begin
                if (hs) begin
                    csum_d = csum_add;
                    if (bidx_q == 2'd2) begin
                        bidx_d = 2'd0;
                        if (idx_q == len_q - 8'd1) begin
                            state_d     = StCsum;
                            byte_data_d = csum_add;
                        end else begin
                            idx_d       = idx_q + 8'd1;
                            byte_data_d = {6'd0, rd_sample.channel};
                        end
                    end else begin
                        bidx_d      = bidx_q + 2'd1;
                        byte_data_d = (bidx_q == 2'd0) ? rd_sample.data[15:8]
                                                       : rd_sample.data[7:0];
                    end
                end
            end
            StCsum: begin
                if (hs) begin
                    state_d      = StFill;
                    byte_valid_d = 1'b0;
                    byte_data_d  = 8'd0;
                    seq_d        = seq_q + 8'd1;
                    count_d      = 8'd0;
                    csum_d       = 8'd0;
                    pkt_done_d   = 1'b1;
                end
            end
            default: state_d = StFill;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_ft232h_reset_n) begin
        if (!i_ft232h_reset_n) begin
            state_q      <= StFill;
            count_q      <= 8'd0;
            seq_q        <= 8'd0;
            len_q        <= 8'd0;
            csum_q       <= 8'd0;
            idx_q        <= 8'd0;
            bidx_q       <= 2'd0;
            byte_data_q  <= 8'd0;
            byte_valid_q <= 1'b0;
            pkt_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            seq_q        <= seq_d;
            len_q        <= len_d;
            csum_q       <= csum_d;
            idx_q        <= idx_d;
            bidx_q       <= bidx_d;
            byte_data_q  <= byte_data_d;
            byte_valid_q <= byte_valid_d;
            pkt_done_q   <= pkt_done_d;
        end
    end

    assign o_sample_ready = (state_q == StFill);
    assign o_busy         = (state_q != StFill);
    assign o_byte_data    = byte_data_q;
    assign o_byte_valid   = byte_valid_q;
    assign o_pkt_done     = pkt_done_q;

endmodule

// File: tb/tb_ft232h_tx_packetizer.sv
// Directed bench for ft232h_tx_packetizer with a byte scoreboard built from a packet model.
module tb_ft232h_tx_packetizer;

    localparam int unsigned N = 8;
    localparam logic [7:0]  SYNC = 8'hA5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] i_sample_data = '0;
    logic [1:0]  i_sample_channel = '0;
    logic        i_sample_valid = 1'b0;
    logic        o_sample_ready;
    logic        i_flush = 1'b0;
    logic [7:0]  o_byte_data;
    logic        o_byte_valid;
    logic        i_byte_ready = 1'b1;
    logic        o_busy;
    logic        o_pkt_done;

    ft232h_tx_packetizer #(
        .SAMPLES_PER_PKT (N),
        .SYNC_BYTE       (SYNC)
    ) dut (
        .i_clk            (clk),
        .i_ft232h_reset_n (rst_n),
        .i_sample_data    (i_sample_data),
        .i_sample_channel (i_sample_channel),
        .i_sample_valid   (i_sample_valid),
        .o_sample_ready   (o_sample_ready),
        .i_flush          (i_flush),
        .o_byte_data      (o_byte_data),
        .o_byte_valid     (o_byte_valid),
        .i_byte_ready     (i_byte_ready),
        .o_busy           (o_busy),
        .o_pkt_done       (o_pkt_done)
    );

    always #5 clk = ~clk;

    int unsigned passed = 0;
    int unsigned total = 0;
    int unsigned failed = 0;
    int unsigned done_cnt = 0;
    int unsigned done_exp = 0;
    logic [7:0]  exp_q [$];
    logic [1:0]  pch [$];
    logic [15:0] pdat [$];
    logic [7:0]  model_seq = 8'd0;
    logic        rand_rdy = 1'b0;
    logic        hold_chk = 1'b0;
    logic [7:0]  held = 8'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_pkt();
        logic [7:0] cs;
        logic [7:0] len;
        len = 8'(pch.size());
        exp_q.push_back(SYNC);
        exp_q.push_back(model_seq);
        exp_q.push_back(len);
        cs = model_seq + len;
        for (int i = 0; i < pch.size(); i++) begin
            exp_q.push_back({6'd0, pch[i]});
            exp_q.push_back(pdat[i][15:8]);
            exp_q.push_back(pdat[i][7:0]);
            cs = cs + {6'd0, pch[i]} + pdat[i][15:8] + pdat[i][7:0];
        end
        exp_q.push_back(cs);
        model_seq++;
        done_exp++;
        pch.delete();
        pdat.delete();
    endtask

    // One clock cycle, entered and left just after a falling edge.
    task automatic cyc();
        logic [7:0] e;
        i_byte_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        if (hold_chk) chk("hold_stable", {23'd0, o_byte_valid, o_byte_data}, {23'd0, 1'b1, held});
        chk("ready_vs_busy", {31'd0, o_sample_ready}, {31'd0, !o_busy});
        if (o_byte_valid && i_byte_ready) begin
            chk("byte_expected", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("byte_data", {24'd0, o_byte_data}, {24'd0, e});
            end
        end
        hold_chk = o_byte_valid && !i_byte_ready;
        held = o_byte_data;
        @(posedge clk);
        @(negedge clk);
        if (o_pkt_done) done_cnt++;
    endtask

    task automatic drive(input logic v, input logic [1:0] ch, input logic [15:0] d,
                         input logic fl);
        logic rdy;
        i_sample_valid = v;
        i_sample_channel = ch;
        i_sample_data = d;
        i_flush = fl;
        rdy = o_sample_ready;
        if (v && rdy) begin
            pch.push_back(ch);
            pdat.push_back(d);
        end
        if (rdy && (pch.size() == N || (fl && pch.size() > 0))) push_pkt();
        cyc();
        i_sample_valid = 1'b0;
        i_flush = 1'b0;
    endtask

    task automatic drain(input int unsigned maxc, output int unsigned n);
        n = 0;
        while (exp_q.size() > 0 && n < maxc) begin
            if (!rand_rdy) chk("ready_low_in_pkt", {31'd0, o_sample_ready}, 32'd0);
            cyc();
            n++;
        end
        chk("drain_complete", exp_q.size(), 32'd0);
    endtask

    initial begin
        int unsigned n;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ready", {31'd0, o_sample_ready}, 32'd1);
        chk("rst_valid", {31'd0, o_byte_valid}, 32'd0);
        chk("rst_data", {24'd0, o_byte_data}, 32'd0);
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_done", {31'd0, o_pkt_done}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single sample, then flush
        drive(1'b1, 2'd1, 16'h1234, 1'b0);
        drive(1'b0, 2'd0, 16'h0000, 1'b1);
        chk("sync_latency_valid", {31'd0, o_byte_valid}, 32'd1);
        chk("sync_latency_data", {24'd0, o_byte_data}, {24'd0, SYNC});
        drain(20, n);
        chk("single_len_cycles", n, 32'd7);
        chk("single_done", done_cnt, done_exp);
        chk("single_ready_back", {31'd0, o_sample_ready}, 32'd1);

        // Full packet, ready held high
        for (int s = 0; s < N; s++) drive(1'b1, 2'd0, 16'(s), 1'b0);
        drain(40, n);
        chk("full_drain_cycles", n, 32'd28);
        chk("full_done", done_cnt, done_exp);

        // Same packet with random backpressure
        rand_rdy = 1'b1;
        for (int s = 0; s < N; s++) drive(1'b1, 2'd0, 16'(s), 1'b0);
        drain(400, n);
        rand_rdy = 1'b0;
        hold_chk = 1'b0;
        chk("rand_done", done_cnt, done_exp);

        // 257 back-to-back packets, SEQ wraps
        for (int p = 0; p < 257; p++) begin
            for (int s = 0; s < N; s++) drive(1'b1, 2'(p), {8'(p), 8'(s)}, 1'b0);
            drain(40, n);
        end
        chk("wrap_done", done_cnt, done_exp);

        // Flush with empty buffer is ignored
        drive(1'b0, 2'd0, 16'h0000, 1'b1);
        for (int i = 0; i < 40; i++) cyc();
        chk("empty_flush_busy", {31'd0, o_busy}, 32'd0);
        chk("empty_flush_done", done_cnt, done_exp);

        // Flush with the 3rd sample, then flush during payload
        drive(1'b1, 2'd2, 16'hBEEF, 1'b0);
        drive(1'b1, 2'd3, 16'h0102, 1'b0);
        drive(1'b1, 2'd1, 16'hFF80, 1'b1);
        chk("flush3_len_total", exp_q.size(), 32'd13);
        for (int i = 0; i < 6 && exp_q.size() > 0; i++) cyc();
        drive(1'b0, 2'd0, 16'h0000, 1'b1);
        drain(40, n);
        for (int i = 0; i < 40; i++) cyc();
        chk("payload_flush_busy", {31'd0, o_busy}, 32'd0);
        chk("payload_flush_done", done_cnt, done_exp);

        // Reset during payload
        for (int s = 0; s < N; s++) drive(1'b1, 2'd1, 16'hA000 + 16'(s), 1'b0);
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) cyc();
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, o_byte_valid}, 32'd0);
        chk("midrst_busy", {31'd0, o_busy}, 32'd0);
        chk("midrst_ready", {31'd0, o_sample_ready}, 32'd1);
        exp_q.delete();
        pch.delete();
        pdat.delete();
        model_seq = 8'd0;
        done_exp--;
        hold_chk = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) cyc();
        for (int s = 0; s < N - 1; s++) begin
            drive(1'b1, 2'd3, 16'h5A00 + 16'(s), 1'b0);
            chk("post_rst_busy", {31'd0, o_busy}, 32'd0);
        end
        drive(1'b1, 2'd3, 16'h5A07, 1'b0);
        drain(40, n);
        chk("post_rst_done", done_cnt, done_exp);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
